fp_to_int_arbiter: RTL and testbench

- Shares one floating_point_to_int converter instance among NUM_REQ requesters.
- Arbitrates round-robin and presents the granted operand and rounding mode to the converter.
- Drives the converter's active-low reset so that each operation starts from the converter's first state with done cleared.
- Monitors done with a watchdog and returns the result, invalid flag and requester id over a valid/ready response channel.

---
 rtl/fp_to_int_arbiter.sv | 155 +++++++++++++++
 tb/tb_fp_to_int_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_to_int_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fp_to_int_arbiter
// Description : Round-robin sharing of one float-to-int converter among
//               NUM_REQ requesters, with a done watchdog and a response channel.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_to_int_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int int_size  = 64,
    parameter int precision = 32,
    parameter int TIMEOUT   = 16,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*precision-1:0] req_float,
    input  logic [NUM_REQ*2-1:0]         req_conv,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         cvt_reset,
    output logic [precision-1:0]         cvt_float,
    output logic [1:0]                   cvt_conv,
    input  logic                         cvt_done,
    input  logic [int_size-1:0]          cvt_int,
    input  logic                         cvt_invalid,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [ID_W-1:0]              rsp_id,
    output logic [int_size-1:0]          rsp_int,
    output logic                         rsp_invalid,
    output logic                         rsp_timeout,
    output logic                         busy
);

    localparam int              CNT_W      = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [ID_W-1:0]        r_last_grant;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_cvt_reset;
    logic [precision-1:0]   r_cvt_float;
    logic [1:0]             r_cvt_conv;
    logic                   r_rsp_valid;
    logic [ID_W-1:0]        r_rsp_id;
    logic [int_size-1:0]    r_rsp_int;
    logic                   r_rsp_invalid;
    logic                   r_rsp_timeout;

    logic                   w_any;
    logic [ID_W-1:0]        w_grant_idx;
    logic [precision-1:0]   w_grant_float;
    logic [1:0]             w_grant_conv;
    logic [NUM_REQ-1:0]     w_ready;

    function automatic logic [ID_W-1:0] wrap_idx(input int unsigned base, input int unsigned off);
        int unsigned s;
        s = base + off;
        if (s >= unsigned'(NUM_REQ))
            s = s - unsigned'(NUM_REQ);
        return ID_W'(s);
    endfunction

    // Scan from farthest to nearest so the nearest valid requester after
    // last_grant is the final (winning) assignment.
    always_comb begin
        w_grant_idx = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (req_valid[wrap_idx(32'(r_last_grant), i)])
                w_grant_idx = wrap_idx(32'(r_last_grant), i);
        end
        w_any         = |req_valid;
        w_grant_float = req_float[int'(w_grant_idx)*precision +: precision];
        w_grant_conv  = req_conv[int'(w_grant_idx)*2 +: 2];
        w_ready       = '0;
        if (r_state == S_IDLE && w_any)
            w_ready[w_grant_idx] = 1'b1;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_any) w_state_next = S_BUSY;
            S_BUSY:    if (cvt_done || r_cnt == c_CNT_LAST) w_state_next = S_RESPOND;
            S_RESPOND: if (rsp_ready) w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_last_grant  <= ID_W'(NUM_REQ - 1);
            r_cnt         <= '0;
            r_cvt_reset   <= 1'b0;
            r_cvt_float   <= '0;
            r_cvt_conv    <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_id      <= '0;
            r_rsp_int     <= '0;
            r_rsp_invalid <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            // Converter runs only while BUSY, so every operation starts clean.
            r_cvt_reset <= (w_state_next == S_BUSY);
            r_rsp_valid <= (w_state_next == S_RESPOND);
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_cvt_float  <= w_grant_float;
                        r_cvt_conv   <= w_grant_conv;
                        r_rsp_id     <= w_grant_idx;
                        r_last_grant <= w_grant_idx;
                        r_cnt        <= '0;
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (cvt_done) begin
                        r_rsp_int     <= cvt_int;
                        r_rsp_invalid <= cvt_invalid;
                        r_rsp_timeout <= 1'b0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_rsp_int     <= '0;
                        r_rsp_invalid <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready   = w_ready;
    assign cvt_reset   = r_cvt_reset;
    assign cvt_float   = r_cvt_float;
    assign cvt_conv    = r_cvt_conv;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_id      = r_rsp_id;
    assign rsp_int     = r_rsp_int;
    assign rsp_invalid = r_rsp_invalid;
    assign rsp_timeout = r_rsp_timeout;
    assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fp_to_int_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_to_int_arbiter
// Description : Directed self-checking bench with a behavioural converter stub.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_to_int_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ISZ     = 64;
    localparam int PREC    = 32;
    localparam int TMO     = 16;
    localparam int IDW     = 2;

    localparam logic [31:0] c_F_PI  = 32'h40490FDB;
    localparam logic [31:0] c_F_1   = 32'h3F800000;
    localparam logic [31:0] c_F_2   = 32'h40000000;
    localparam logic [31:0] c_F_3   = 32'h40400000;
    localparam logic [31:0] c_F_4   = 32'h40800000;
    localparam logic [31:0] c_F_NAN = 32'h7FC00000;

    logic                      clk;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*PREC-1:0]   req_float;
    logic [NUM_REQ*2-1:0]      req_conv;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      cvt_reset;
    logic [PREC-1:0]           cvt_float;
    logic [1:0]                cvt_conv;
    logic                      cvt_done;
    logic [ISZ-1:0]            cvt_int;
    logic                      cvt_invalid;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [IDW-1:0]            rsp_id;
    logic [ISZ-1:0]            rsp_int;
    logic                      rsp_invalid;
    logic                      rsp_timeout;
    logic                      busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    fp_to_int_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .int_size  (ISZ),
        .precision (PREC),
        .TIMEOUT   (TMO)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_float   (req_float),
        .req_conv    (req_conv),
        .req_ready   (req_ready),
        .cvt_reset   (cvt_reset),
        .cvt_float   (cvt_float),
        .cvt_conv    (cvt_conv),
        .cvt_done    (cvt_done),
        .cvt_int     (cvt_int),
        .cvt_invalid (cvt_invalid),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_int     (rsp_int),
        .rsp_invalid (rsp_invalid),
        .rsp_timeout (rsp_timeout),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) cyc <= cyc + 1;

    // Converter stub: three stepping states after leaving reset, done on the fourth edge.
    logic [1:0] stub_stage;
    logic       stub_dead;

    function automatic logic [64:0] stub_result(input logic [31:0] f, input logic [1:0] c);
        case (f)
            c_F_PI:  return {1'b0, (c == 2'd1) ? 64'd4 : 64'd3};
            c_F_1:   return {1'b0, 64'd1};
            c_F_2:   return {1'b0, 64'd2};
            c_F_3:   return {1'b0, 64'd3};
            c_F_4:   return {1'b0, 64'd4};
            c_F_NAN: return {1'b1, {64{1'b1}}};
            default: return 65'd0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge cvt_reset) begin
        if (!cvt_reset) begin
            stub_stage  <= 2'd0;
            cvt_done    <= 1'b0;
            cvt_int     <= '0;
            cvt_invalid <= 1'b0;
        end else if (stub_stage != 2'd3) begin
            stub_stage <= stub_stage + 2'd1;
        end else if (!stub_dead) begin
            cvt_done                <= 1'b1;
            {cvt_invalid, cvt_int}  <= stub_result(cvt_float, cvt_conv);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [31:0] f, input logic [1:0] c);
        req_float[idx*PREC +: PREC] = f;
        req_conv[idx*2 +: 2]        = c;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    int n;
    int t_prev;

    initial begin
        #200000;
        $display("FAIL global_timeout: got=hang want=finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        req_valid = '0;
        req_float = '0;
        req_conv  = '0;
        rsp_ready = 1'b1;
        stub_dead = 1'b0;
        t_prev    = 0;
        tick();
        tick();
        check("rst_busy",      64'(busy), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_cvt_reset", 64'(cvt_reset), 64'd0);
        check("rst_rsp_int",   rsp_int, 64'd0);
        check("rst_cvt_float", 64'(cvt_float), 64'd0);
        reset = 1'b1;
        tick();
        check("idle_ready", 64'(req_ready), 64'd0);

        // Single request on requester 2
        set_req(2, c_F_PI, 2'd3);
        req_valid = 4'b0100;
        #1;
        check("t1_ready", 64'(req_ready), 64'b0100);
        tick();
        req_valid = '0;
        check("t1_ready_after", 64'(req_ready), 64'd0);
        check("t1_cvt", {30'd0, cvt_conv, cvt_float}, {30'd0, 2'd3, c_F_PI});
        check("t1_cvt_reset", 64'(cvt_reset), 64'd1);
        wait_rsp(n);
        check("t1_latency", 64'(n), 64'd5);
        check("t1_id", 64'(rsp_id), 64'd2);
        check("t1_int", rsp_int, 64'd3);
        check("t1_flags", {62'd0, rsp_invalid, rsp_timeout}, 64'd0);
        check("t1_cvt_reset_rsp", 64'(cvt_reset), 64'd0);
        tick();
        check("t1_handshake", {62'd0, rsp_valid, busy}, 64'd0);

        // Round robin over all four, starting from a fresh reset
        reset = 1'b0;
        #2;
        reset = 1'b1;
        set_req(0, c_F_1, 2'd0);
        set_req(1, c_F_2, 2'd0);
        set_req(2, c_F_3, 2'd0);
        set_req(3, c_F_4, 2'd0);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_rsp(n);
            check("rr_id", 64'(rsp_id), 64'(k % 4));
            check("rr_int", rsp_int, 64'(k % 4 + 1));
            if (k > 0) check("rr_spacing", 64'(cyc - t_prev), 64'd7);
            t_prev = cyc;
            if (k == 4) req_valid = '0;
            tick();
        end

        // NaN on requester 1
        set_req(1, c_F_NAN, 2'd0);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        wait_rsp(n);
        check("nan_id", 64'(rsp_id), 64'd1);
        check("nan_int", rsp_int, {64{1'b1}});
        check("nan_flags", {62'd0, rsp_invalid, rsp_timeout}, 64'b10);
        tick();

        // Dead converter: watchdog fires
        stub_dead = 1'b1;
        set_req(3, c_F_1, 2'd0);
        req_valid = 4'b1000;
        tick();
        req_valid = '0;
        wait_rsp(n);
        check("tmo_latency", 64'(n), 64'd16);
        check("tmo_id", 64'(rsp_id), 64'd3);
        check("tmo_int", rsp_int, 64'd0);
        check("tmo_flags", {62'd0, rsp_invalid, rsp_timeout}, 64'b11);
        tick();
        stub_dead = 1'b0;

        // Back-pressure with requester 0 holding its request
        rsp_ready = 1'b0;
        set_req(0, c_F_2, 2'd0);
        set_req(1, c_F_3, 2'd0);
        req_valid = 4'b0001;
        tick();
        wait_rsp(n);
        for (int k = 0; k < 10; k++) begin
            check("stall_ctl", {55'd0, rsp_valid, rsp_id, rsp_invalid, rsp_timeout, req_ready},
                  {55'd0, 1'b1, 2'd0, 1'b0, 1'b0, 4'b0000});
            check("stall_int", rsp_int, 64'd2);
            tick();
        end
        req_valid = 4'b0011;
        rsp_ready = 1'b1;
        tick();
        check("bp_next_grant", 64'(req_ready), 64'b0010);
        tick();
        req_valid = 4'b0001;
        wait_rsp(n);
        check("bp_id", 64'(rsp_id), 64'd1);
        check("bp_int", rsp_int, 64'd3);
        tick();
        check("bp_back_to_0", 64'(req_ready), 64'b0001);
        tick();
        req_valid = '0;

        // Reset pulsed mid-BUSY
        tick();
        tick();
        check("mid_busy", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        check("mid_rst", {61'd0, busy, rsp_valid, cvt_reset}, 64'd0);
        #2;
        reset = 1'b1;
        tick();
        check("post_rst_idle", {62'd0, busy, rsp_valid}, 64'd0);
        req_valid = 4'b1111;
        #1;
        check("post_rst_grant", 64'(req_ready), 64'b0001);
        tick();
        req_valid = '0;
        wait_rsp(n);
        check("post_rst_id", 64'(rsp_id), 64'd0);
        check("post_rst_int", rsp_int, 64'd2);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
